// File: rtl/rvv_backend_alu_result_buf.sv
// rtl/rvv_backend_alu_result_buf.sv - per-lane buffered ALU result merge stage feeding the ROB
// Optional ALU_MULTIHIT_CHECK_EN adds a sticky per-lane multihit_err flag.
module rvv_backend_alu_result_buf #(
  parameter int NUM_LANE = 2,
  parameter int NUM_SUB  = 4,
  parameter int RES_W    = 128,
  parameter int DEPTH    = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_LANE-1:0]               in_valid,
  output logic [NUM_LANE-1:0]               in_ready,
  input  logic [NUM_LANE*NUM_SUB-1:0]       sub_valid,
  input  logic [NUM_LANE*NUM_SUB*RES_W-1:0] sub_result,
  output logic [NUM_LANE-1:0]               out_valid,
  input  logic [NUM_LANE-1:0]               out_ready,
  output logic [NUM_LANE*RES_W-1:0]         out_result,
`ifdef ALU_MULTIHIT_CHECK_EN
  output logic [NUM_LANE-1:0]               multihit_err,
`endif
  output logic [NUM_LANE*$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
    logic [RES_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [RES_W-1:0] sel_word;
    logic             found;
    logic             push;
    logic             pop;

    // Lowest-index valid candidate wins; no candidate yields an all-zero word.
    always_comb begin
      sel_word = '0;
      found    = 1'b0;
      for (int s = 0; s < NUM_SUB; s++) begin
        if (sub_valid[l*NUM_SUB+s] && !found) begin
          sel_word = sub_result[(l*NUM_SUB+s)*RES_W +: RES_W];
          found    = 1'b1;
        end
      end
    end

    assign in_ready[l] = (count != FULL);
    assign out_valid[l] = (count != '0);
    assign push = in_valid[l] && in_ready[l];
    assign pop  = out_valid[l] && out_ready[l];
    assign out_result[l*RES_W +: RES_W] = (count != '0) ? mem[rd_ptr] : '0;
    assign occupancy[l*CNT_W +: CNT_W] = count;

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= sel_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end

`ifdef ALU_MULTIHIT_CHECK_EN
    logic multi;

    always_comb begin
      multi = 1'b0;
      for (int s = 1; s < NUM_SUB; s++) begin
        for (int t = 0; t < s; t++) begin
          if (sub_valid[l*NUM_SUB+s] && sub_valid[l*NUM_SUB+t]) multi = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) multihit_err[l] <= 1'b0;
      else if (push && multi) multihit_err[l] <= 1'b1;
    end
`endif
  end

endmodule

// File: doc/rvv_backend_alu_result_buf.md
Name: rvv_backend_alu_result_buf

Overview:
- Parametrised, buffered successor of the single-cycle ALU result merge stage.
- Accepts per-lane ALU uop handshakes and NUM_SUB parallel sub-unit result candidates per lane (addsub/shift/mask/other and future units).
- Selects one candidate per lane by fixed priority and stores it in a per-lane FIFO.
- Drains each FIFO to the ROB with a valid/ready handshake, so ROB back-pressure no longer stalls the combinational sub-units.

Parameters:
- NUM_LANE, 2, number of independent ALU lanes.
- NUM_SUB, 4, sub-unit candidates per lane; index 0 has highest priority.
- RES_W, 128, width of one PU2ROB_t result word.
- DEPTH, 4, entries per lane FIFO; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  NUM_LANE  uop valid from ALU RS, per lane.
- in_ready  out  NUM_LANE  lane FIFO can accept.
- sub_valid  in  NUM_LANE*NUM_SUB  sub-unit result valid; lane l, sub s at bit l*NUM_SUB+s.
- sub_result  in  NUM_LANE*NUM_SUB*RES_W  sub-unit results, same ordering.
- out_valid  out  NUM_LANE  result available to ROB.
- out_ready  in  NUM_LANE  ROB accepts.
- out_result  out  NUM_LANE*RES_W  FIFO head per lane.
- occupancy  out  NUM_LANE*$clog2(DEPTH+1)  entries held per lane.
- multihit_err  out  NUM_LANE  sticky multiple-hit flag; present only with ALU_MULTIHIT_CHECK_EN.

Behaviour:
- Reset (async, rst_n=0), all lanes:
  - read pointer, write pointer and count cleared to 0.
  - out_valid=0, out_result=0, occupancy=0, multihit_err=0.
  - in_ready=1 is driven from the cleared count.
- Reset mid-operation discards all stored entries immediately. No partial pop is visible to the ROB.
- Lanes are fully independent. No cross-lane ordering is enforced; ordering is the ROB's responsibility.
- Push occurs when in_valid & in_ready.
  - The pushed word is sub_result of the lowest-index s with sub_valid set.
  - If no sub_valid bit is set, the pushed word is all-zero. This matches the legacy default.
- in_ready = (count != DEPTH).
  - in_ready is a function of registered state only and has no combinational path from out_ready.
  - A push while full is impossible, since in_ready=0.
  - in_valid with in_ready=0 is ignored. RS must hold the uop.
- Pop occurs when out_valid & out_ready.
  - out_valid = (count != 0).
  - out_result = mem[rd_ptr].
  - out_ready while empty has no effect.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
  - At count==1 the new word becomes the head next cycle.
  - At count==DEPTH no push happens (in_ready=0); the pop alone proceeds.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Latency: a word pushed in cycle N appears on out_valid/out_result in cycle N+1. There is no bypass.
- out_valid held high with out_ready low keeps out_result stable until the pop.
- Throughput: 1 result per lane per cycle at steady state when out_ready is held at 1.
- occupancy equals count, registered.
- Memory needs no reset. out_result is forced to 0 while count==0.

Optional Feature:
- ALU_MULTIHIT_CHECK_EN defined:
  - On a push where more than one sub_valid bit of that lane is set, multihit_err[l] sets.
  - The flag stays set until rst_n.
  - The data pushed is still the priority selection.
- ALU_MULTIHIT_CHECK_EN undefined:
  - multihit_err port and its logic are absent.
  - No other behaviour changes.

Test Plan:
- Reset, then lane0 pushes with sub_valid=4'b0100, sub_result[2]=0xA5.. and out_ready=1 -> cycle+1: out_valid[0]=1, out_result=0xA5.., occupancy=1. Cycle+2: occupancy=0.
- Lane0, out_ready=0, push 5 uops with DEPTH=4 -> in_ready[0]=0 after the 4th push, the 5th is held, occupancy=4. Set out_ready=1 -> words pop in order 1..4; in_ready rises after the first pop.
- At count=4, assert in_valid and out_ready together -> pop only, occupancy goes 4->3. Next cycle: push and pop together, occupancy stays 3.
- sub_valid=4'b1010 with distinct words -> sub 1 word stored. With ALU_MULTIHIT_CHECK_EN: multihit_err[0]=1 and remains set. With sub_valid=0: stored word is 0.
- Lane1 full and stalled while lane0 streams 10 results with out_ready=1 -> lane0 sustains 1/cycle, lane1 contents unchanged.
- Assert rst_n=0 asynchronously with count=3 -> out_valid=0 and occupancy=0 immediately, without a clock edge. After release, in_ready=1.
